// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI read-channel types and arbiter encodings for the read arbiter slice.
// Imported by the selector and the arbiter top.
package axi_read_arbiter_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef logic [2:0] axi_size_t;
    typedef logic [1:0] axi_burst_type_t;
    typedef logic [1:0] axi_resp_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axi_read_arbiter_rr_select.sv
// Combinational request selector: round-robin search from ptr (wrapping) or
// lowest-index-first when mode is set. Shared by read and write arbiters.
module rr_select
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    input  logic                   mode,
    output logic [IDX_W-1:0]       idx,
    output logic                   found
);

    logic [IDX_W-1:0]                  start;
    logic [NUM_MASTERS-1:0][IDX_W-1:0] cand;

    assign start = mode ? '0 : ptr;

    // cand[gi] is the index visited at search offset gi, wrapped into range.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, start} + (IDX_W+1)'(gi);
        assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_MASTERS))
                         ? IDX_W'(sum - (IDX_W+1)'(NUM_MASTERS))
                         : sum[IDX_W-1:0];
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk offsets high to low so the smallest offset is the final winner.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx   = cand[i];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Per-burst arbiter sharing one AXI read slave among NUM_MASTERS masters,
// with a beat-count check of every burst against its captured arlen.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = ARB_RR,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_MASTERS-1:0][AXI_ADDR_WIDTH-1:0]  m_araddr,
    input  logic [NUM_MASTERS-1:0][7:0]                 m_arlen,
    input  axi_size_t [NUM_MASTERS-1:0]                 m_arsize,
    input  axi_burst_type_t [NUM_MASTERS-1:0]           m_arburst,
    input  logic [NUM_MASTERS-1:0]                      m_arvalid,
    output logic [NUM_MASTERS-1:0]                      m_arready,
    output logic [NUM_MASTERS-1:0][AXI_DATA_WIDTH-1:0]  m_rdata,
    output logic [NUM_MASTERS-1:0]                      m_rlast,
    output logic [NUM_MASTERS-1:0]                      m_rvalid,
    output axi_resp_t [NUM_MASTERS-1:0]                 m_rresp,
    input  logic [NUM_MASTERS-1:0]                      m_rready,
    output logic [AXI_ADDR_WIDTH-1:0]                   s_araddr,
    output logic [7:0]                                  s_arlen,
    output axi_size_t                                   s_arsize,
    output axi_burst_type_t                             s_arburst,
    output logic                                        s_arvalid,
    input  logic                                        s_arready,
    input  logic [AXI_DATA_WIDTH-1:0]                   s_rdata,
    input  logic                                        s_rlast,
    input  axi_resp_t                                   s_rresp,
    input  logic                                        s_rvalid,
    output logic                                        s_rready,
    output logic                                        err_pulse,
    output logic [IDX_W-1:0]                            err_master
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic             err_seen_q, err_seen_d;
    logic             err_pulse_q, err_pulse_d;
    logic [IDX_W-1:0] err_master_q, err_master_d;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             sel_mode;
    logic             r_hs;

    assign sel_mode = (ARB_MODE == ARB_FIXED);

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_select (
        .req   (m_arvalid),
        .ptr   (rr_ptr_q),
        .mode  (sel_mode),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Read data and response are broadcast; only m_rvalid qualifies them.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_bcast
        assign m_rdata[gi] = s_rdata;
        assign m_rresp[gi] = s_rresp;
    end

    assign r_hs       = s_rvalid && m_rready[grant_q];
    assign err_pulse  = err_pulse_q;
    assign err_master = err_master_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        err_seen_d   = err_seen_q;
        err_pulse_d  = 1'b0;
        err_master_d = err_master_q;

        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_araddr  = m_araddr[grant_q];
        s_arlen   = m_arlen[grant_q];
        s_arsize  = m_arsize[grant_q];
        s_arburst = m_arburst[grant_q];

        case (state_q)
            ARB_IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
                if (m_arvalid[grant_q] && s_arready) begin
                    len_d      = m_arlen[grant_q];
                    beat_cnt_d = '0;
                    err_seen_d = 1'b0;
                    state_d    = ARB_DATA;
                end
            end
            ARB_DATA: begin
                m_rvalid[grant_q] = s_rvalid;
                m_rlast[grant_q]  = s_rlast;
                s_rready          = m_rready[grant_q];
                if (r_hs) begin
                    if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (s_rlast) begin
                        state_d = ARB_IDLE;
                        if (ARB_MODE == ARB_RR) begin
                            rr_ptr_d = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                        end
                        if (beat_cnt_q != len_q && !err_seen_q) begin
                            err_pulse_d  = 1'b1;
                            err_master_d = grant_q;
                            err_seen_d   = 1'b1;
                        end
                    end else if (beat_cnt_q == len_q && !err_seen_q) begin
                        // Last expected beat without rlast: flag once, keep
                        // draining until the slave finally ends the burst.
                        err_pulse_d  = 1'b1;
                        err_master_d = grant_q;
                        err_seen_d   = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_seen_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_seen_q   <= err_seen_d;
            err_pulse_q  <= err_pulse_d;
            err_master_q <= err_master_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench: a round-robin and a fixed-priority arbiter run side by side,
// each checked every cycle against a burst-level ownership model.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int NM   = 3;
    localparam int IW   = $clog2(NM);
    localparam int AW   = AXI_ADDR_WIDTH;
    localparam int DW   = AXI_DATA_WIDTH;
    localparam int NCYC = 2400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0][AW-1:0]    m_araddr  [2];
    logic [NM-1:0][7:0]       m_arlen   [2];
    axi_size_t [NM-1:0]       m_arsize  [2];
    axi_burst_type_t [NM-1:0] m_arburst [2];
    logic [NM-1:0]            m_arvalid [2];
    logic [NM-1:0]            m_arready [2];
    logic [NM-1:0][DW-1:0]    m_rdata   [2];
    logic [NM-1:0]            m_rlast   [2];
    logic [NM-1:0]            m_rvalid  [2];
    axi_resp_t [NM-1:0]       m_rresp   [2];
    logic [NM-1:0]            m_rready  [2];
    logic [AW-1:0]            s_araddr  [2];
    logic [7:0]               s_arlen   [2];
    axi_size_t                s_arsize  [2];
    axi_burst_type_t          s_arburst [2];
    logic                     s_arvalid [2];
    logic                     s_arready [2];
    logic [DW-1:0]            s_rdata   [2];
    logic                     s_rlast   [2];
    axi_resp_t                s_rresp   [2];
    logic                     s_rvalid  [2];
    logic                     s_rready  [2];
    logic                     err_pulse [2];
    logic [IW-1:0]            err_master[2];

    // Instance 0 runs round-robin, instance 1 fixed priority.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        axi_read_arbiter #(
            .NUM_MASTERS (NM),
            .ARB_MODE    (gi)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .m_araddr   (m_araddr[gi]),
            .m_arlen    (m_arlen[gi]),
            .m_arsize   (m_arsize[gi]),
            .m_arburst  (m_arburst[gi]),
            .m_arvalid  (m_arvalid[gi]),
            .m_arready  (m_arready[gi]),
            .m_rdata    (m_rdata[gi]),
            .m_rlast    (m_rlast[gi]),
            .m_rvalid   (m_rvalid[gi]),
            .m_rresp    (m_rresp[gi]),
            .m_rready   (m_rready[gi]),
            .s_araddr   (s_araddr[gi]),
            .s_arlen    (s_arlen[gi]),
            .s_arsize   (s_arsize[gi]),
            .s_arburst  (s_arburst[gi]),
            .s_arvalid  (s_arvalid[gi]),
            .s_arready  (s_arready[gi]),
            .s_rdata    (s_rdata[gi]),
            .s_rlast    (s_rlast[gi]),
            .s_rresp    (s_rresp[gi]),
            .s_rvalid   (s_rvalid[gi]),
            .s_rready   (s_rready[gi]),
            .err_pulse  (err_pulse[gi]),
            .err_master (err_master[gi])
        );
    end

    // Burst-level model: who owns the slave, whether its address is accepted,
    // how many beats it asked for and how many it has received.
    int            owner   [2];
    bit            in_data [2];
    int            rr      [2];
    int            want    [2];
    int            got     [2];
    bit            errd    [2];
    bit            err_p   [2];
    int            err_m   [2];
    logic [NM-1:0] ar_done [2];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_total++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic int pick(input logic [NM-1:0] req, input int fixed_mode, input int ptr);
        int c;
        pick = -1;
        for (int n = 0; n < NM; n++) begin
            c = (fixed_mode != 0) ? n : (ptr + n) % NM;
            if (req[c] && pick < 0) pick = c;
        end
    endfunction

    task automatic model_reset(input int k);
        owner[k]   = -1;
        in_data[k] = 1'b0;
        rr[k]      = 0;
        want[k]    = 0;
        got[k]     = 0;
        errd[k]    = 1'b0;
        err_p[k]   = 1'b0;
        err_m[k]   = 0;
        ar_done[k] = '0;
    endtask

    task automatic drive_inputs(input int k, input int cyc);
        int  preq;
        bit  fair;
        bit  base;
        fair = (cyc >= 1500 && cyc < 1800);
        preq = fair ? 100 : 30;
        for (int i = 0; i < NM; i++) begin
            if (ar_done[k][i]) m_arvalid[k][i] = 1'b0;
            if (!m_arvalid[k][i] && $urandom_range(0, 99) < preq) begin
                m_arvalid[k][i] = 1'b1;
                m_araddr[k][i]  = $urandom & 32'hFFFF_FFFC;
                m_arlen[k][i]   = fair ? 8'd0 : 8'($urandom_range(0, 5));
                m_arsize[k][i]  = 3'($urandom_range(0, 2));
                m_arburst[k][i] = 2'($urandom_range(0, 2));
            end
            if (cyc >= 1900 && cyc < 2000 && i == 1)
                m_rready[k][i] = ($urandom_range(0, 9) < 2);
            else
                m_rready[k][i] = ($urandom_range(0, 9) < 8);
        end
        ar_done[k] = '0;
        // Rare protocol break: the owner withdraws its request mid-address phase.
        if (!fair && owner[k] >= 0 && !in_data[k] && $urandom_range(0, 49) == 0)
            m_arvalid[k][owner[k]] = 1'b0;
        s_arready[k] = 1'($urandom_range(0, 1));
        s_rvalid[k]  = ($urandom_range(0, 3) != 0);
        s_rdata[k]   = $urandom;
        s_rresp[k]   = 2'($urandom_range(0, 3));
        base         = in_data[k] ? (got[k] >= want[k]) : 1'($urandom_range(0, 1));
        s_rlast[k]   = ($urandom_range(0, 15) == 0) ? !base : base;
    endtask

    task automatic check_outputs(input int k, input int cyc);
        logic [NM-1:0] e_arready;
        logic [NM-1:0] e_rvalid;
        logic [NM-1:0] e_rlast;
        logic          e_sarv;
        logic          e_srr;
        string         pfx;
        e_arready = '0;
        e_rvalid  = '0;
        e_rlast   = '0;
        e_sarv    = 1'b0;
        e_srr     = 1'b0;
        pfx = $sformatf("i%0d c%0d", k, cyc);
        if (owner[k] >= 0 && !in_data[k]) begin
            e_sarv              = m_arvalid[k][owner[k]];
            e_arready[owner[k]] = s_arready[k];
            check_eq({pfx, " s_ar_fields"},
                     64'({s_araddr[k], s_arlen[k], s_arsize[k], s_arburst[k]}),
                     64'({m_araddr[k][owner[k]], m_arlen[k][owner[k]],
                          m_arsize[k][owner[k]], m_arburst[k][owner[k]]}));
        end
        if (owner[k] >= 0 && in_data[k]) begin
            e_rvalid[owner[k]] = s_rvalid[k];
            e_rlast[owner[k]]  = s_rlast[k];
            e_srr              = m_rready[k][owner[k]];
        end
        check_eq({pfx, " s_arvalid"},  64'(s_arvalid[k]),  64'(e_sarv));
        check_eq({pfx, " m_arready"},  64'(m_arready[k]),  64'(e_arready));
        check_eq({pfx, " m_rvalid"},   64'(m_rvalid[k]),   64'(e_rvalid));
        check_eq({pfx, " m_rlast"},    64'(m_rlast[k]),    64'(e_rlast));
        check_eq({pfx, " s_rready"},   64'(s_rready[k]),   64'(e_srr));
        check_eq({pfx, " err_pulse"},  64'(err_pulse[k]),  64'(err_p[k]));
        check_eq({pfx, " err_master"}, 64'(err_master[k]), 64'(err_m[k]));
        for (int i = 0; i < NM; i++)
            check_eq($sformatf("%s rdata_resp%0d", pfx, i),
                     64'({m_rresp[k][i], m_rdata[k][i]}), 64'({s_rresp[k], s_rdata[k]}));
    endtask

    task automatic model_step(input int k);
        bit flag;
        int w;
        flag = 1'b0;
        if (rst) begin
            model_reset(k);
            return;
        end
        if (owner[k] < 0) begin
            w = pick(m_arvalid[k], k, rr[k]);
            if (w >= 0) begin
                owner[k]   = w;
                in_data[k] = 1'b0;
            end
        end else if (!in_data[k]) begin
            if (m_arvalid[k][owner[k]] && s_arready[k]) begin
                want[k]              = int'(m_arlen[k][owner[k]]);
                got[k]               = 0;
                errd[k]              = 1'b0;
                in_data[k]           = 1'b1;
                ar_done[k][owner[k]] = 1'b1;
            end
        end else if (s_rvalid[k] && m_rready[k][owner[k]]) begin
            if (s_rlast[k] ? (got[k] != want[k]) : (got[k] == want[k])) begin
                if (!errd[k]) begin
                    flag     = 1'b1;
                    errd[k]  = 1'b1;
                    err_m[k] = owner[k];
                end
            end
            if (got[k] < 255) got[k]++;
            if (s_rlast[k]) begin
                rr[k]      = (owner[k] + 1) % NM;
                owner[k]   = -1;
                in_data[k] = 1'b0;
            end
        end
        err_p[k] = flag;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_araddr[k]  = '0;
            m_arlen[k]   = '0;
            m_arsize[k]  = '0;
            m_arburst[k] = '0;
            m_arvalid[k] = '0;
            m_rready[k]  = '0;
            s_arready[k] = 1'b0;
            s_rdata[k]   = '0;
            s_rlast[k]   = 1'b0;
            s_rresp[k]   = '0;
            s_rvalid[k]  = 1'b0;
            model_reset(k);
        end
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3) || (cyc == 1800) || (cyc == 2100);
            for (int k = 0; k < 2; k++) drive_inputs(k, cyc);
            #1;
            for (int k = 0; k < 2; k++) begin
                check_outputs(k, cyc);
                model_step(k);
            end
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

- Shares one AXI read slave port among `NUM_MASTERS` AXI read masters, for example the instruction cache, the data cache and a future page-table walker.
- Arbitrates per burst: a granted master owns the AR and R channels until the slave completes its burst with `rlast`.
- Checks each burst's beat count against the captured `arlen` and reports any mismatch.
- Sits between the cache layer and the memory-side `axi_read_if`.

## Interface

Parameters:
- `NUM_MASTERS`, 2: number of upstream masters, ≥ 2.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `IDX_W`, `$clog2(NUM_MASTERS)`: grant index width.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `m_araddr`  in  `[NUM_MASTERS-1:0][AXI_ADDR_WIDTH-1:0]`  per-master read address
- `m_arlen`  in  `[NUM_MASTERS-1:0][7:0]`  per-master burst length minus one
- `m_arsize`  in  `axi_size_t [NUM_MASTERS-1:0]`  per-master beat size
- `m_arburst`  in  `axi_burst_type_t [NUM_MASTERS-1:0]`  per-master burst type
- `m_arvalid`  in  `NUM_MASTERS`  per-master address valid
- `m_arready`  out  `NUM_MASTERS`  per-master address ready
- `m_rdata`  out  `[NUM_MASTERS-1:0][AXI_DATA_WIDTH-1:0]`  read data, broadcast to all masters
- `m_rlast`, `m_rvalid`  out  `NUM_MASTERS` each  per-master last beat and data valid
- `m_rresp`  out  `axi_resp_t [NUM_MASTERS-1:0]`  read response, broadcast to all masters
- `m_rready`  in  `NUM_MASTERS`  per-master data ready
- `s_araddr`, `s_arlen`, `s_arsize`, `s_arburst`, `s_arvalid`  out  as the AXI master side of `axi_read_if`
- `s_arready`, `s_rdata`, `s_rlast`, `s_rresp`, `s_rvalid`  in  slave responses
- `s_rready`  out  1  data ready to the slave
- `err_pulse`  out  1  one-cycle beat-count mismatch flag
- `err_master`  out  `IDX_W`  master that owned the faulty burst

## Operation

State machine `arb_state_t` has three states: `ARB_IDLE`, `ARB_ADDR`, `ARB_DATA`.

`ARB_IDLE`
- Select a winner among the asserted `m_arvalid` bits.
- Round-robin mode: search upward from `rr_ptr`, wrapping from `NUM_MASTERS-1` to 0.
- Fixed-priority mode: lowest asserted index wins.
- Register the winner in `grant`, then go to `ARB_ADDR`.
- With no requests, stay in `ARB_IDLE`.

`ARB_ADDR`
- Drive all `s_ar*` outputs from `m_ar*[grant]`.
- `m_arready[grant] = s_arready`.
- On `s_arvalid && s_arready`: capture `arlen` into `len_q`, clear `beat_cnt`, go to `ARB_DATA`.

`ARB_DATA`
- `m_rvalid[grant] = s_rvalid`, `m_rlast[grant] = s_rlast`, `s_rready = m_rready[grant]`.
- On each R handshake, `beat_cnt` increments (8-bit, no wrap; `arlen` ≤ 255).
- On an R handshake with `s_rlast = 1`:
  - return to `ARB_IDLE`;
  - round-robin mode: `rr_ptr <= grant + 1`, taken modulo `NUM_MASTERS`.

Output gating
- Non-granted masters see `m_arready = 0`, `m_rvalid = 0` and `m_rlast = 0` in every state.
- `m_rdata` and `m_rresp` are broadcast to all masters; only `m_rvalid` qualifies them.

Beat-count check
- Early `rlast` (`rlast` with `beat_cnt != len_q`): `err_pulse` fires; the FSM still returns to `ARB_IDLE`.
- Missing `rlast` (beat `beat_cnt == len_q` handshakes without `rlast`): `err_pulse` fires; the FSM stays in `ARB_DATA` until `rlast` arrives.
- Only one error is flagged per burst.

## Timing

Reset
- `state = ARB_IDLE`, `grant = 0`, `rr_ptr = 0`, `len_q = 0`, `beat_cnt = 0`.
- All `valid`/`ready` outputs are 0; `err_pulse = 0`; `err_master = 0`.

Latency and throughput
- `m_arvalid` seen in `ARB_IDLE` at cycle t gives `s_arvalid = 1` at t+1.
- An R handshake with `rlast` at cycle t returns to `ARB_IDLE` at t+1; the next `s_arvalid` rises no earlier than t+2.
- R-channel routing is combinational: zero added latency per beat, full throughput within a burst.
- `err_pulse` is registered: high exactly one cycle, the cycle after the offending handshake. `err_master` holds the faulty burst's master until the next error.

Boundary conditions
- Simultaneous requests are resolved by `ARB_MODE`.
- A request arriving during `ARB_ADDR` or `ARB_DATA` waits; it is never dropped.
- A master deasserting `m_arvalid` in `ARB_ADDR` breaks protocol. The arbiter does not re-arbitrate; it waits in `ARB_ADDR`.
- `rst` mid-burst drops to `ARB_IDLE` on the next edge; flushing the slave is the system's responsibility.

## Structure

- `arb_state_t` and the `ARB_MODE` encodings (`ARB_RR`, `ARB_FIXED`) go in `_riscv_defines`.
- Reuse the existing AXI typedefs and widths from `_riscv_defines`.
- One sub-module, `rr_select`: combinational selector with inputs `req[NUM_MASTERS]`, `ptr` and `mode`, outputs `idx` and `found`. It is reusable by later write-side arbiters.

## Test plan

- **Single master:** `NUM_MASTERS = 2`; master 0 requests `araddr = 0x1000`, `arlen = 3` → `s_araddr = 0x1000` at t+1; 4 beats delivered only to master 0; `ARB_IDLE` after `rlast`; `err_pulse` stays 0.
- **Round-robin fairness:** both masters hold `arvalid` continuously with `arlen = 0` → grants alternate 0,1,0,1; the gap between consecutive `s_arvalid` rises is ≥ 2 cycles.
- **Fixed priority:** `ARB_MODE = 1`; masters 0 and 1 both request → master 0 is always granted; master 1 is granted only when master 0 idles.
- **Early `rlast`:** `arlen = 3`, slave asserts `rlast` on beat 2 → `err_pulse = 1` for one cycle, `err_master = grant`, FSM back in `ARB_IDLE`.
- **Backpressure and reset:** `m_rready[1]` low for 5 cycles mid-burst → `s_rready` low and no beats lost. Then `rst` pulsed mid-burst → all outputs 0 and `rr_ptr = 0` the next cycle.
